// File: rtl/ghash_block_aligner.sv
// GHASH input-stage block aligner.
// Prepends zero "bubble" blocks at the head of a message so that the final
// parallel word handed to the GHASH core is completely full. The blocks
// displaced from the tail of each input word are carried in a residual
// register into the head of the next output word.
//
// Handshake: i_valid qualifies i_data for one cycle and there is no
// back-pressure. Every accepted input word in RUN produces exactly one
// o_valid pulse on the next cycle. o_valid, o_skip_bus and o_last_word are
// single-cycle pulses, and o_data holds its value between pulses.
module ghash_block_aligner #(
    parameter  int NB_N_MESSAGES       = 10,
    parameter  int LOG2_BLOCK_PROC_PAR = 2,
    parameter  int NB_BLOCK            = 128,
    localparam int BLOCK_PROC_PAR      = 2**LOG2_BLOCK_PROC_PAR
) (
    input  logic                               i_clock,
    input  logic                               i_reset,
    input  logic                               i_start,
    input  logic [NB_N_MESSAGES:0]             i_rf_static_n_messages,
    input  logic [NB_BLOCK*BLOCK_PROC_PAR-1:0] i_data,
    input  logic                               i_valid,
    input  logic                               i_hash_done,
    output logic [NB_BLOCK*BLOCK_PROC_PAR-1:0] o_data,
    output logic                               o_valid,
    output logic [NB_N_MESSAGES-1:0]           o_msg_count,
    output logic [LOG2_BLOCK_PROC_PAR-1:0]     o_msg_bubbles,
    output logic                               o_skip_bus,
    output logic                               o_last_word,
    output logic                               o_busy
);

    localparam int NB_WORD = NB_BLOCK*BLOCK_PROC_PAR;
    localparam int NB_LEN  = NB_N_MESSAGES+1;
    // Rounding term for the word count, one bit wider than the length so
    // the maximum length plus PAR-1 cannot overflow.
    localparam logic [NB_LEN:0] C_ROUND = (NB_LEN+1)'(BLOCK_PROC_PAR-1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    state_t                   r_state;
    logic [NB_LEN-1:0]        r_total_words;
    logic [NB_LEN-1:0]        r_word_cnt;
    logic [NB_WORD-1:0]       r_resid;

    logic [LOG2_BLOCK_PROC_PAR-1:0] w_start_bubbles;
    logic [NB_LEN:0]          w_total_full;
    logic [NB_LEN-1:0]        w_start_total;
    logic                     w_last;
    int                       w_bub;
    logic [NB_WORD-1:0]       w_aligned;
    logic [NB_WORD-1:0]       w_resid_next;

    // Bubbles = (-n) mod PAR, taken from the low LOG2 bits of the length.
    assign w_start_bubbles = '0 - i_rf_static_n_messages[LOG2_BLOCK_PROC_PAR-1:0];
    assign w_total_full    = ({1'b0, i_rf_static_n_messages} + C_ROUND) >> LOG2_BLOCK_PROC_PAR;
    assign w_start_total   = w_total_full[NB_LEN-1:0];
    assign w_last          = (r_word_cnt == (r_total_words - 1'b1));
    assign w_bub           = int'(o_msg_bubbles);
    assign o_busy          = (r_state != ST_IDLE);

    // Lane mux: output lane k takes residual lane k below the bubble count,
    // otherwise input lane k-bubbles. The displaced tail lanes of the input
    // are packed at the head of the next residual. Lane 0 is the MSB slice.
    always_comb begin
        w_aligned    = '0;
        w_resid_next = '0;
        for (int k = 0; k < BLOCK_PROC_PAR; k++) begin
            if (k < w_bub) begin
                w_aligned[(BLOCK_PROC_PAR-1-k)*NB_BLOCK +: NB_BLOCK] =
                    r_resid[(BLOCK_PROC_PAR-1-k)*NB_BLOCK +: NB_BLOCK];
                w_resid_next[(BLOCK_PROC_PAR-1-k)*NB_BLOCK +: NB_BLOCK] =
                    i_data[(w_bub-1-k)*NB_BLOCK +: NB_BLOCK];
            end else begin
                w_aligned[(BLOCK_PROC_PAR-1-k)*NB_BLOCK +: NB_BLOCK] =
                    i_data[(BLOCK_PROC_PAR-1-k+w_bub)*NB_BLOCK +: NB_BLOCK];
            end
        end
    end

    // Message FSM with registered outputs, counters and residual buffer.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_total_words <= '0;
            r_word_cnt    <= '0;
            r_resid       <= '0;
            o_data        <= '0;
            o_valid       <= 1'b0;
            o_msg_count   <= '0;
            o_msg_bubbles <= '0;
            o_skip_bus    <= 1'b0;
            o_last_word   <= 1'b0;
        end else begin
            o_valid     <= 1'b0;
            o_skip_bus  <= 1'b0;
            o_last_word <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_total_words <= w_start_total;
                        r_word_cnt    <= '0;
                        r_resid       <= '0;
                        o_msg_bubbles <= w_start_bubbles;
                        if (i_rf_static_n_messages == '0) begin
                            // Empty message: a single all-zero skip word.
                            o_data      <= '0;
                            o_valid     <= 1'b1;
                            o_skip_bus  <= 1'b1;
                            o_last_word <= 1'b1;
                            o_msg_count <= '0;
                            r_state     <= ST_WAIT_DONE;
                        end else begin
                            r_state     <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (i_valid) begin
                        o_data      <= w_aligned;
                        r_resid     <= w_resid_next;
                        o_valid     <= 1'b1;
                        o_msg_count <= NB_N_MESSAGES'(r_word_cnt << LOG2_BLOCK_PROC_PAR);
                        r_word_cnt  <= r_word_cnt + 1'b1;
                        if (w_last) begin
                            o_last_word <= 1'b1;
                            r_state     <= ST_WAIT_DONE;
                        end
                    end
                end
                ST_WAIT_DONE: begin
                    if (i_hash_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ghash_block_aligner.sv
// Testbench for ghash_block_aligner: table of message cases, hand-written
// reset / handshake sequences and randomized messages, all checked by a
// scoreboard fed from a block-list reference model.
module tb_ghash_block_aligner;

  localparam int NB_N  = 10;
  localparam int LOG2  = 2;
  localparam int PAR   = 4;
  localparam int NB    = 128;
  localparam int NW    = NB*PAR;
  localparam int EXP_W = NW + NB_N + 2;

  typedef struct {
    int n;
    int max_gap;
    int exp_bub;
    int exp_words;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            i_reset = 1'b1;
  logic            i_start = 1'b0;
  logic [NB_N:0]   i_n = '0;
  logic [NW-1:0]   i_data = '0;
  logic            i_valid = 1'b0;
  logic            i_hash_done = 1'b0;
  logic [NW-1:0]   o_data;
  logic            o_valid;
  logic [NB_N-1:0] o_msg_count;
  logic [LOG2-1:0] o_msg_bubbles;
  logic            o_skip_bus;
  logic            o_last_word;
  logic            o_busy;

  always #5 clk = ~clk;

  ghash_block_aligner #(
    .NB_N_MESSAGES(NB_N),
    .LOG2_BLOCK_PROC_PAR(LOG2),
    .NB_BLOCK(NB)
  ) dut (
    .i_clock(clk),
    .i_reset(i_reset),
    .i_start(i_start),
    .i_rf_static_n_messages(i_n),
    .i_data(i_data),
    .i_valid(i_valid),
    .i_hash_done(i_hash_done),
    .o_data(o_data),
    .o_valid(o_valid),
    .o_msg_count(o_msg_count),
    .o_msg_bubbles(o_msg_bubbles),
    .o_skip_bus(o_skip_bus),
    .o_last_word(o_last_word),
    .o_busy(o_busy)
  );

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] mon_act;
  logic [EXP_W-1:0] mon_exp;
  int n_cmp = 0;
  int n_bad = 0;
  int out_cnt = 0;

  function automatic logic [EXP_W-1:0] pack_exp(logic [NW-1:0] d, int cnt, bit last, bit skip);
    logic [NB_N-1:0] c;
    c = cnt[NB_N-1:0];
    return {d, c, last, skip};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Every output pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (o_valid) begin
      n_cmp++;
      out_cnt++;
      mon_act = {o_data, o_msg_count, o_last_word, o_skip_bus};
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_word: got o_valid with count %0d, required no output", o_msg_count);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          n_bad++;
          $display("FAIL out_word: got data=%h cnt=%0d last=%b skip=%b, required data=%h cnt=%0d last=%b skip=%b",
                   mon_act[EXP_W-1 -: NW], mon_act[NB_N+1:2], mon_act[1], mon_act[0],
                   mon_exp[EXP_W-1 -: NW], mon_exp[NB_N+1:2], mon_exp[1], mon_exp[0]);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [NW-1:0] rand_word();
    logic [NW-1:0] w;
    for (int i = 0; i < NW/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic int model_bub(int n);
    return (PAR - (n % PAR)) % PAR;
  endfunction

  function automatic int model_words(int n);
    return (n == 0) ? 1 : (n + PAR - 1) / PAR;
  endfunction

  // Message = bubble zeros followed by the blocks, cut into PAR-block words.
  task automatic model_msg(input int n, input logic [NB-1:0] blks[$], input int limit);
    logic [NB-1:0] padded[$];
    logic [NW-1:0] d;
    int nw;
    if (n == 0) begin
      exp_q.push_back(pack_exp('0, 0, 1'b1, 1'b1));
      return;
    end
    for (int i = 0; i < model_bub(n); i++) padded.push_back('0);
    foreach (blks[i]) padded.push_back(blks[i]);
    nw = model_words(n);
    for (int w = 0; w < nw && w < limit; w++) begin
      d = '0;
      for (int k = 0; k < PAR; k++) d[(PAR-1-k)*NB +: NB] = padded[w*PAR+k];
      exp_q.push_back(pack_exp(d, w*PAR, (w == nw-1), 1'b0));
    end
  endtask

  // Input word w: message blocks w*PAR.., junk beyond the message end.
  function automatic logic [NW-1:0] in_word(input logic [NB-1:0] blks[$], int n, int w);
    logic [NW-1:0] d;
    d = rand_word();
    for (int k = 0; k < PAR; k++)
      if (w*PAR+k < n) d[(PAR-1-k)*NB +: NB] = blks[w*PAR+k];
    return d;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic make_blocks(input int n, output logic [NB-1:0] blks[$]);
    blks = {};
    for (int i = 0; i < n; i++) blks.push_back({$urandom, $urandom, $urandom, $urandom});
  endtask

  // Start pulse; a junk i_valid rides along and must be ignored.
  task automatic drive_start(input int n);
    i_start = 1'b1;
    i_n     = (NB_N+1)'(n);
    i_valid = 1'b1;
    i_data  = rand_word();
    tick();
    i_start = 1'b0;
    i_valid = 1'b0;
  endtask

  // Input words with random gaps; stray start/done in gaps must be ignored.
  task automatic drive_words(input logic [NB-1:0] blks[$], input int n, input int nw, input int max_gap);
    for (int w = 0; w < nw; w++) begin
      repeat ($urandom_range(0, max_gap)) begin
        i_hash_done = 1'($urandom_range(0, 1));
        i_start     = 1'($urandom_range(0, 1));
        i_n         = (NB_N+1)'($urandom_range(0, 2047));
        i_data      = rand_word();
        tick();
      end
      i_hash_done = 1'b0;
      i_start     = 1'b0;
      i_valid     = 1'b1;
      i_data      = in_word(blks, n, w);
      tick();
      i_valid     = 1'b0;
    end
  endtask

  // Full message: start, words, drain, dropped extras, done handshake.
  task automatic run_msg(input int n, input int max_gap, input bit start_on_done,
                         output int words_seen, output int bub_seen);
    logic [NB-1:0] blks[$];
    make_blocks(n, blks);
    model_msg(n, blks, 1 << 30);
    out_cnt = 0;
    drive_start(n);
    if (n != 0) drive_words(blks, n, (n + PAR - 1) / PAR, max_gap);
    tick();
    tick();
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    check("busy_wait_done", 64'(o_busy), 64'd1);
    words_seen = out_cnt;
    bub_seen   = int'(o_msg_bubbles);
    // Extra words in WAIT_DONE are dropped.
    i_valid = 1'b1;
    i_data  = rand_word();
    tick();
    tick();
    i_valid     = 1'b0;
    i_hash_done = 1'b1;
    if (start_on_done) begin
      i_start = 1'b1;
      i_n     = (NB_N+1)'(3);
    end
    tick();
    i_hash_done = 1'b0;
    i_start     = 1'b0;
    check("busy_after_done", 64'(o_busy), 64'd0);
    tick();
    check("busy_idle_hold", 64'(o_busy), 64'd0);
  endtask

  // Abort a message with reset after some words, then run a fresh one.
  task automatic reset_mid(input int n1, input int words_before, input int n2);
    logic [NB-1:0] blks[$];
    int ws;
    int bs;
    make_blocks(n1, blks);
    model_msg(n1, blks, words_before);
    drive_start(n1);
    drive_words(blks, n1, words_before, 0);
    tick();
    check("pre_reset_drain", 64'(exp_q.size()), 64'd0);
    i_reset = 1'b1;
    i_valid = 1'b1;
    i_data  = rand_word();
    tick();
    i_reset = 1'b0;
    i_valid = 1'b0;
    check("rst_data", 64'(o_data != '0), 64'd0);
    check("rst_flags", 64'({o_valid, o_skip_bus, o_last_word, o_busy}), 64'd0);
    check("rst_count", 64'(o_msg_count), 64'd0);
    check("rst_bubbles", 64'(o_msg_bubbles), 64'd0);
    run_msg(n2, 0, 1'b0, ws, bs);
    check("post_rst_words", 64'(ws), 64'(model_words(n2)));
    check("post_rst_bub", 64'(bs), 64'(model_bub(n2)));
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[8];
  int ws;
  int bs;
  int rn;

  initial begin
    vecs[0] = '{n: 8,    max_gap: 0, exp_bub: 0, exp_words: 2};
    vecs[1] = '{n: 6,    max_gap: 0, exp_bub: 2, exp_words: 2};
    vecs[2] = '{n: 1,    max_gap: 0, exp_bub: 3, exp_words: 1};
    vecs[3] = '{n: 0,    max_gap: 0, exp_bub: 0, exp_words: 1};
    vecs[4] = '{n: 9,    max_gap: 3, exp_bub: 3, exp_words: 3};
    vecs[5] = '{n: 7,    max_gap: 2, exp_bub: 1, exp_words: 2};
    vecs[6] = '{n: 1024, max_gap: 0, exp_bub: 0, exp_words: 256};
    vecs[7] = '{n: 1023, max_gap: 1, exp_bub: 1, exp_words: 256};

    repeat (3) tick();
    check("reset_data", 64'(o_data != '0), 64'd0);
    check("reset_flags", 64'({o_valid, o_skip_bus, o_last_word, o_busy}), 64'd0);
    i_reset = 1'b0;
    tick();
    check("idle_busy", 64'(o_busy), 64'd0);

    foreach (vecs[i]) begin
      run_msg(vecs[i].n, vecs[i].max_gap, 1'b0, ws, bs);
      check($sformatf("vec%0d_words", i), 64'(ws), 64'(vecs[i].exp_words));
      check($sformatf("vec%0d_bub", i), 64'(bs), 64'(vecs[i].exp_bub));
    end

    // Start in the same cycle as hash_done is dropped.
    run_msg(5, 1, 1'b1, ws, bs);
    check("done_start_words", 64'(ws), 64'd2);

    reset_mid(12, 1, 4);
    reset_mid(10, 2, 5);

    for (int r = 0; r < 25; r++) begin
      rn = (r % 5 == 0) ? 0 : $urandom_range(1, 40);
      run_msg(rn, $urandom_range(0, 3), 1'($urandom_range(0, 1)), ws, bs);
      check("rand_words", 64'(ws), 64'(model_words(rn)));
      check("rand_bub", 64'(bs), 64'(model_bub(rn)));
    end

    repeat (3) tick();
    check("final_queue", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    n_bad++;
    $display("FAIL timeout: simulation did not complete within 50000 cycles");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ghash_block_aligner.md
Name: ghash_block_aligner

Overview:
- Input stage directly upstream of the GHASH control/multiplier core.
- Accepts message blocks BLOCK_PROC_PAR at a time and prepends (msg_bubbles) zero blocks at the message head so the final parallel word is completely full.
- Produces the per-word block count, bubble count, skip flag and valid that the GHASH control signal unit consumes.
- One FSM, a residual-lane buffer and a word counter. Latency is 1 cycle.

Parameters:
NB_N_MESSAGES, 10, width of block counter; max message length 2^NB_N_MESSAGES blocks
LOG2_BLOCK_PROC_PAR, 2, log2 of blocks per parallel word; localparam BLOCK_PROC_PAR = 2**LOG2_BLOCK_PROC_PAR
NB_BLOCK, 128, bits per GHASH block

Ports:
i_clock  in  1  single clock, all logic on posedge
i_reset  in  1  synchronous, active-high reset
i_start  in  1  begin message; samples i_rf_static_n_messages
i_rf_static_n_messages  in  NB_N_MESSAGES+1  message length in blocks
i_data  in  NB_BLOCK*BLOCK_PROC_PAR  input word; lane 0 = MSB slice = earliest block
i_valid  in  1  i_data valid
i_hash_done  in  1  completion pulse from GHASH control
o_data  out  NB_BLOCK*BLOCK_PROC_PAR  aligned word, same lane order
o_valid  out  1  o_data valid
o_msg_count  out  NB_N_MESSAGES  blocks (incl. bubbles) emitted before this word
o_msg_bubbles  out  LOG2_BLOCK_PROC_PAR  latched bubble count, stable for the whole message
o_skip_bus  out  1  empty message marker, qualified by o_valid
o_last_word  out  1  final word of message, qualified by o_valid
o_busy  out  1  high in RUN and WAIT_DONE

Behaviour:
- Reset (sync, high): state=IDLE. All outputs, counters and the residual register are 0. Reset overrides every other input in the same cycle, including mid-message. A reset mid-message discards the message with no flush.
- Start latch:
  - Derived values:
    - bubbles = (BLOCK_PROC_PAR - (n mod BLOCK_PROC_PAR)) mod BLOCK_PROC_PAR, using only the low LOG2 bits of n.
    - total_words = (n + BLOCK_PROC_PAR-1) >> LOG2, computed at NB_N_MESSAGES+1 bits with no overflow.
  - IDLE & i_start: latch n, bubbles and total_words. Clear word_cnt and the residual register.
  - If n != 0: go to RUN.
  - If n == 0: in the next cycle emit one word with o_data=0, o_valid=1, o_skip_bus=1, o_last_word=1, o_msg_count=0. Then go to WAIT_DONE.
  - i_valid in the same cycle as i_start is ignored.
- RUN, on each i_valid:
  - o_data is registered. Lanes 0..bubbles-1 = residual (all zeros for the first word). Lanes bubbles..PAR-1 = input lanes 0..PAR-1-bubbles.
  - Input lanes PAR-bubbles..PAR-1 are stored into the residual register.
  - o_valid=1 for one cycle. o_msg_count = word_cnt*BLOCK_PROC_PAR, truncated to NB_N_MESSAGES bits.
  - word_cnt increments.
  - When word_cnt == total_words-1: o_last_word=1 and go to WAIT_DONE.
  - Input lanes beyond n in the last input word are don't-care. Their residual is discarded, so there is no extra flush word.
- Gaps: i_valid low in RUN produces o_valid=0, and o_data holds its previous value. Counters and residual hold. There is no timeout.
- WAIT_DONE:
  - i_valid is ignored (extra words dropped) and i_start is ignored.
  - i_hash_done goes to IDLE. If i_start arrives in the same cycle it is ignored and must be reissued.
- i_hash_done outside WAIT_DONE: ignored.
- i_start outside IDLE: ignored.
- Output hold rules:
  - o_valid, o_skip_bus and o_last_word are single-cycle pulses.
  - o_msg_bubbles updates at the start latch and holds until the next start.
- Widths: BLOCK_PROC_PAR=1 (LOG2=0) degenerates to bubbles=0 and a pass-through. Lane selection must be a parameterised mux with no hardcoded 4.
- Max length n=2^NB_N_MESSAGES: the final o_msg_count = n-BLOCK_PROC_PAR fits in NB_N_MESSAGES bits.

Test Plan:
- n=8, words A0..A3 then A4..A7 -> bubbles 0; out {A0..A3} count 0, {A4..A7} count 4 last=1; 1-cycle latency each.
- n=6, words {B0,B1,B2,B3}, {B4,B5,x,x} -> bubbles 2; out {0,0,B0,B1} count 0, {B2,B3,B4,B5} count 4 last=1.
- n=1, word {C0,x,x,x} -> bubbles 3; single out {0,0,0,C0} last=1, count 0.
- n=0 start -> one o_valid cycle with data 0, skip=1, last=1; i_valid in WAIT_DONE yields no output; i_hash_done returns to IDLE (o_busy=0).
- n=9 with i_valid gaps of 0..3 cycles between words -> 3 words, bubbles 3, counts 0,4,8, lanes correct across gaps.
- Reset asserted after first word of n=12, then fresh start n=4 -> outputs 0 after reset, new message starts with zero residual, count 0, last=1.
